// File: rtl/iterative_shifter.sv
// Multi-cycle barrel-free shifter: applies one 1-bit shift per clock until the count expires.
// Rotate ops (011 ROL, 100 ROR) exist only when ITERATIVE_SHIFTER_ROTATE_EN is defined.
module iterative_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5   // must satisfy 2**SHAMT_W == WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out
);

  // state | meaning
  // IDLE  | waiting for start, data_out holds last result
  // SHIFT | one 1-bit shift per cycle while count is non-zero
  // DONE  | result valid for one cycle; a new start is accepted here
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [2:0]         op_q;
  logic [SHAMT_W-1:0] cnt;

  function automatic logic op_known(input logic [2:0] o);
    case (o)
      3'b000, 3'b001, 3'b010: return 1'b1;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      3'b011, 3'b100:         return 1'b1;
`endif
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] d, input logic [2:0] o);
    case (o)
      3'b000:  return {d[WIDTH-2:0], 1'b0};
      3'b001:  return {1'b0, d[WIDTH-1:1]};
      3'b010:  return {d[WIDTH-1], d[WIDTH-1:1]};
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      3'b011:  return {d[WIDTH-2:0], d[WIDTH-1]};
      3'b100:  return {d[0], d[WIDTH-1:1]};
`endif
      default: return d;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= 3'b000;
      cnt      <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            data_out <= data_in;
            op_q     <= op;
            // reserved codes run as a zero-length shift so latency stays uniform
            cnt      <= op_known(op) ? shamt : '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            data_out <= shift1(data_out, op_q);
            cnt      <= cnt - SHAMT_W'(1);
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter: transaction-level model checked every cycle,
// directed literal cases, then randomized traffic with stray starts and resets.
module tb_iterative_shifter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] data_in = 32'h0;
  logic        busy, done;
  logic [31:0] data_out;

  int errors = 0;
  int checks = 0;

  iterative_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt),
    .data_in(data_in), .busy(busy), .done(done), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit op_valid(input logic [2:0] o);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    return o <= 3'd4;
`else
    return o <= 3'd2;
`endif
  endfunction

  // Whole-amount result of applying op k times, from plain arithmetic.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [2:0] o, input int k);
    logic signed [31:0] sd;
    sd = d;
    if (!op_valid(o)) return d;
    case (o)
      3'd0:    return d << k;
      3'd1:    return d >> k;
      3'd2:    return sd >>> k;
      3'd3:    return (k == 0) ? d : ((d << k) | (d >> (32 - k)));
      default: return (k == 0) ? d : ((d >> k) | (d << (32 - k)));
    endcase
  endfunction

  // Model: an accepted start at edge 0 shows min(j,s) shifts after edge j, done at edge s+1.
  bit          m_rst_seen = 0;
  bit          m_active = 0;
  int          m_j = 0;
  int          m_s = 0;
  logic [31:0] m_d = '0;
  logic [31:0] m_hold = '0;
  logic [2:0]  m_op = '0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_rst_seen = 1;
      m_active   = 0;
      m_hold     = '0;
    end else if (m_rst_seen) begin
      if (start && !(m_active && m_j <= m_s)) begin
        m_active = 1;
        m_j      = 0;
        m_op     = op;
        m_d      = data_in;
        m_s      = op_valid(op) ? int'(shamt) : 0;
      end else if (m_active) begin
        m_j++;
        if (m_j > m_s + 1) m_active = 0;
      end
      if (m_active) m_hold = ref_shift(m_d, m_op, (m_j < m_s) ? m_j : m_s);
    end
    @(negedge clk);
    if (m_rst_seen) begin
      check("busy", {31'b0, busy}, {31'b0, m_active && m_j <= m_s});
      check("done", {31'b0, done}, {31'b0, m_active && m_j == m_s + 1});
      check("data_out", data_out, m_hold);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    bit seen;
    seen = 0;
    lat  = 0;
    while (!seen && lat < 64) begin
      tick();
      lat++;
      if (done) seen = 1;
    end
    if (!seen) lat = -1;
  endtask

  task automatic do_op(input string name, input logic [2:0] o, input logic [4:0] s,
                       input logic [31:0] d, input int exp_lat, input logic [31:0] exp_val);
    int lat;
    logic [31:0] res;
    start = 1'b1; op = o; shamt = s; data_in = d;
    tick();
    start = 1'b0; op = 3'($urandom); shamt = 5'($urandom); data_in = $urandom;
    wait_done(lat);
    res = data_out;
    check({name, "_latency"}, lat, exp_lat);
    check(name, res, exp_val);
    tick();
    check({name, "_hold"}, data_out, res);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    // Literal pins on the model itself.
    check("model_sra", ref_shift(32'h80000000, 3'd2, 4), 32'hF8000000);
    check("model_srl", ref_shift(32'h80000000, 3'd1, 4), 32'h08000000);
    check("model_rsv", ref_shift(32'h12345678, 3'd7, 9), 32'h12345678);

    repeat (2) tick();
    check("rst_data", data_out, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    reset = 1'b0;
    tick();

    do_op("sll31",  3'd0, 5'd31, 32'h00000001, 32, 32'h80000000);
    do_op("sra4",   3'd2, 5'd4,  32'h80000000, 5,  32'hF8000000);
    do_op("srl4",   3'd1, 5'd4,  32'h80000000, 5,  32'h08000000);
    do_op("sll0",   3'd0, 5'd0,  32'h12345678, 1,  32'h12345678);
    do_op("rsv111", 3'd7, 5'd9,  32'h12345678, 1,  32'h12345678);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    do_op("ror1",   3'd4, 5'd1,  32'h00000001, 2,  32'h80000000);
    do_op("rol3",   3'd3, 5'd3,  32'hA0000001, 4,  32'h0000000D);
`else
    do_op("ror1",   3'd4, 5'd1,  32'h00000001, 1,  32'h00000001);
    do_op("rol3",   3'd3, 5'd3,  32'hA0000001, 1,  32'hA0000001);
`endif

    // Start while busy is ignored; start in the DONE cycle is taken immediately.
    start = 1'b1; op = 3'd1; shamt = 5'd8; data_in = 32'hFFFF0000;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 64) begin
      if (lat == 2) begin
        start = 1'b1; op = 3'd0; shamt = 5'd1; data_in = 32'h55555555;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    check("busy_ignore_lat", lat, 9);
    check("busy_ignore_val", data_out, 32'h00FFFF00);
    start = 1'b1; op = 3'd0; shamt = 5'd2; data_in = 32'h00000001;
    tick();
    start = 1'b0;
    check("b2b_accept", {31'b0, busy}, 32'h1);
    wait_done(lat);
    check("b2b_lat", lat, 3);
    check("b2b_val", data_out, 32'h00000004);
    tick();

    // Reset mid-shift aborts without a done pulse.
    start = 1'b1; op = 3'd0; shamt = 5'd20; data_in = 32'hDEADBEEF;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_data", data_out, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    repeat (25) tick();

    // Reset and start together: start is dropped.
    reset = 1'b1; start = 1'b1; op = 3'd0; shamt = 5'd3; data_in = 32'h1;
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    check("rst_start_busy", {31'b0, busy}, 32'h0);

    // Random traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 2) == 0);
      op      = 3'($urandom);
      shamt   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
      data_in = $urandom;
      reset   = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; start = 1'b0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
